// File: rtl/fitness_pkg.sv
// +--------------------------------------------------------------------+
// | fitness_pkg : shared FSM state type and sizing helpers for the     |
// |               fitness evaluator.                                   |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package fitness_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic int n_pat(input int n_in);
    return 1 << n_in;
  endfunction

  // Score must hold every output bit of every pattern matching, so 0..N_PAT*N_OUT inclusive.
  function automatic int score_w(input int n_in, input int n_out);
    return $clog2(n_pat(n_in) * n_out + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/match_counter.sv
// +--------------------------------------------------------------------+
// | match_counter : counts bit positions where observed equals         |
// |                 expected (XNOR + popcount), purely combinational.  |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module match_counter #(
  parameter int N_OUT = 1,
  parameter int CNT_W = $clog2(N_OUT + 1)
) (
  input  logic [N_OUT-1:0] i_obs,
  input  logic [N_OUT-1:0] i_exp,
  output logic [CNT_W-1:0] o_count
);

  logic [N_OUT-1:0] w_eq;

  assign w_eq = ~(i_obs ^ i_exp);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < N_OUT; i++) begin
      o_count = o_count + CNT_W'(w_eq[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/fitness_evaluator.sv
// +--------------------------------------------------------------------+
// | fitness_evaluator : sweeps every phenotype input pattern, samples  |
// |                     the response after a settle time and scores it |
// |                     against a latched target truth table.          |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module fitness_evaluator
  import fitness_pkg::*;
#(
  parameter  int N_IN          = 2,
  parameter  int N_OUT         = 1,
  parameter  int SETTLE_CYCLES = 4,
  localparam int N_PAT         = n_pat(N_IN),
  localparam int SCORE_W       = score_w(N_IN, N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N_PAT*N_OUT-1:0] target,
  output logic [N_IN-1:0]        chrom_in,
  input  logic [N_OUT-1:0]       chrom_out,
  output logic                   busy,
  output logic                   done,
  output logic [SCORE_W-1:0]     score,
  output logic                   perfect
);

  localparam int                 CNT_W     = $clog2(SETTLE_CYCLES + 1);
  localparam int                 MC_W      = $clog2(N_OUT + 1);
  localparam logic [SCORE_W-1:0] MAX_SCORE = SCORE_W'(N_PAT * N_OUT);

  state_t                   r_state;
  state_t                   w_next;
  logic [N_PAT*N_OUT-1:0]   r_tgt;
  logic [N_IN-1:0]          r_idx;
  logic [CNT_W-1:0]         r_cnt;
  logic [SCORE_W-1:0]       r_acc;
  logic [N_IN-1:0]          r_chrom_in;
  logic [SCORE_W-1:0]       r_score;
  logic                     r_perfect;
  logic [MC_W-1:0]          w_match;
  logic [SCORE_W-1:0]       w_acc_next;
  logic                     w_settled;
  logic                     w_last;

  match_counter #(
    .N_OUT (N_OUT),
    .CNT_W (MC_W)
  ) u_match (
    .i_obs   (chrom_out),
    .i_exp   (r_tgt[r_idx*N_OUT +: N_OUT]),
    .o_count (w_match)
  );

  assign w_acc_next = r_acc + SCORE_W'(w_match);
  assign w_settled  = (r_cnt == CNT_W'(SETTLE_CYCLES - 1));
  assign w_last     = (r_idx == N_IN'(N_PAT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_APPLY;
      S_APPLY:  if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_APPLY;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Score is committed on the final sample edge so it is already valid during the done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tgt      <= '0;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_chrom_in <= '0;
      r_score    <= '0;
      r_perfect  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tgt      <= target;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_chrom_in <= '0;
          end
        end
        S_APPLY: begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_SAMPLE: begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_score   <= w_acc_next;
            r_perfect <= (w_acc_next == MAX_SCORE);
          end else begin
            r_idx      <= r_idx + N_IN'(1);
            r_cnt      <= '0;
            r_chrom_in <= r_idx + N_IN'(1);
          end
        end
        S_DONE: begin
          r_chrom_in <= '0;
        end
        default: ;
      endcase
    end
  end

  assign chrom_in = r_chrom_in;
  assign score    = r_score;
  assign perfect  = r_perfect;

endmodule

`default_nettype wire

// File: tb/tb_fitness_evaluator.sv
// +--------------------------------------------------------------------+
// | tb_fitness_evaluator : randomized self-checking bench with stub    |
// |                        phenotypes and a truth-table scoring model. |
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fitness_evaluator;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1, start2, start3;
  logic [3:0]  target0, target2, target3;
  logic [15:0] target1;
  logic [1:0]  ci0, ci2, ci3;
  logic [2:0]  ci1;
  logic        co0, co2, co3;
  logic [1:0]  co1;
  logic        busy0, busy1, busy2, busy3;
  logic        done0, done1, done2, done3;
  logic [2:0]  sc0, sc2, sc3;
  logic [4:0]  sc1;
  logic        pf0, pf1, pf2, pf3;

  // Stub phenotypes: truth tables for dut0/dut1, XOR through a 3-cycle delay for dut2/dut3.
  logic [3:0]  tt0;
  logic [15:0] tt1;
  bit   [2:0]  dl2, dl3;

  assign co0 = tt0[ci0];
  assign co1 = tt1[ci1*2 +: 2];
  assign co2 = dl2[2];
  assign co3 = dl3[2];

  always @(posedge clk) begin
    dl2 <= {dl2[1:0], ^ci2};
    dl3 <= {dl3[1:0], ^ci3};
  end

  fitness_evaluator #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .target(target0), .chrom_in(ci0),
    .chrom_out(co0), .busy(busy0), .done(done0), .score(sc0), .perfect(pf0));

  fitness_evaluator #(.N_IN(3), .N_OUT(2), .SETTLE_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .target(target1), .chrom_in(ci1),
    .chrom_out(co1), .busy(busy1), .done(done1), .score(sc1), .perfect(pf1));

  fitness_evaluator #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .target(target2), .chrom_in(ci2),
    .chrom_out(co2), .busy(busy2), .done(done2), .score(sc2), .perfect(pf2));

  fitness_evaluator #(.N_IN(2), .N_OUT(1), .SETTLE_CYCLES(4)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .target(target3), .chrom_in(ci3),
    .chrom_out(co3), .busy(busy3), .done(done3), .score(sc3), .perfect(pf3));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: one point per truth-table bit where the phenotype agrees with the target.
  function automatic int ref_score(input int nbits, input logic [15:0] tt, input logic [15:0] tgt);
    int n = 0;
    for (int i = 0; i < nbits; i++) if (tt[i] == tgt[i]) n++;
    return n;
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start0 = v;
      1: start1 = v;
      2: start2 = v;
      default: start3 = v;
    endcase
  endtask

  task automatic set_target(input int which, input logic [15:0] t);
    case (which)
      0: target0 = t[3:0];
      1: target1 = t;
      2: target2 = t[3:0];
      default: target3 = t[3:0];
    endcase
  endtask

  function automatic logic get_done(input int which);
    case (which)
      0: return done0;
      1: return done1;
      2: return done2;
      default: return done3;
    endcase
  endfunction

  function automatic logic get_busy(input int which);
    case (which)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic int get_score(input int which);
    case (which)
      0: return int'(sc0);
      1: return int'(sc1);
      2: return int'(sc2);
      default: return int'(sc3);
    endcase
  endfunction

  function automatic int get_perf(input int which);
    case (which)
      0: return int'(pf0);
      1: return int'(pf1);
      2: return int'(pf2);
      default: return int'(pf3);
    endcase
  endfunction

  // Cycle c=1 is the cycle right after the start-accepting edge.
  task automatic run(input int which, input logic [15:0] tgt, input bit hold,
                     output int lat, output int dones, output int sc, output int pf,
                     output int sc_mid);
    @(negedge clk);
    set_target(which, tgt);
    set_start(which, 1'b1);
    @(posedge clk);
    if (!hold) begin
      #1;
      set_start(which, 1'b0);
    end
    lat = 0; dones = 0; sc = 0; pf = 0; sc_mid = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 2) sc_mid = get_score(which);
      if (hold && c == 7) set_target(which, ~tgt);
      if (which == 0 && c <= 20 && (c % 5) == 3) chk("chrom_in", 32'(ci0), 32'((c - 1) / 5));
      if (get_done(which)) begin
        dones++;
        if (lat == 0) begin
          lat = c;
          sc  = get_score(which);
          pf  = get_perf(which);
        end
      end
      if (lat != 0 && c == lat + 1) begin
        chk("busy_after_done", 32'(get_busy(which)), 0);
        set_start(which, 1'b0);
      end
      if (lat != 0 && c >= lat + 4) break;
    end
    set_start(which, 1'b0);
  endtask

  initial begin
    int lat, dones, sc, pf, sc_mid, exp_sc, cnt;
    logic [15:0] rtgt;

    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    target0 = '0; target1 = '0; target2 = '0; target3 = '0;
    tt0 = '0; tt1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_done", 32'(done0), 0);
    chk("rst_score", 32'(sc0), 0);
    chk("rst_perfect", 32'(pf0), 0);
    chk("rst_chrom_in", 32'(ci0), 0);
    chk("rst_score1", 32'(sc1), 0);
    rst = 1'b0;

    // XOR phenotype against its own truth table
    tt0 = 4'b0110;
    run(0, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("xor_latency", lat, 21);
    chk("xor_score", sc, 4);
    chk("xor_perfect", pf, 1);
    chk("xor_dones", dones, 1);

    tt0 = 4'b1000;
    run(0, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("score_held", sc_mid, 4);
    chk("and_score", sc, 1);
    chk("and_perfect", pf, 0);

    tt0 = 4'b0000;
    run(0, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("zero_score", sc, 2);

    // start held high, target flipped mid-run
    tt0 = 4'b0110;
    run(0, 16'h0006, 1'b1, lat, dones, sc, pf, sc_mid);
    chk("hold_score", sc, 4);
    chk("hold_dones", dones, 1);
    chk("hold_latency", lat, 21);

    // reset in the middle of a run
    @(negedge clk);
    target0 = 4'b0110;
    start0  = 1'b1;
    @(posedge clk);
    #1 start0 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy0), 0);
    chk("midrst_chrom_in", 32'(ci0), 0);
    chk("midrst_score", 32'(sc0), 0);
    chk("midrst_perfect", 32'(pf0), 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0 || busy0) cnt++;
    end
    chk("midrst_no_done", cnt, 0);
    run(0, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("fresh_score", sc, 4);
    chk("fresh_latency", lat, 21);

    // reset and start together
    @(negedge clk);
    rst = 1'b1;
    start0 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start0 = 1'b0;
    chk("rst_wins", 32'(busy0), 0);
    @(negedge clk);
    chk("rst_wins_later", 32'(busy0), 0);

    // delayed phenotype: enough settle vs too little
    run(3, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("delay_s4_score", sc, 4);
    chk("delay_s4_latency", lat, 21);
    run(2, 16'h0006, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("delay_s2_latency", lat, 13);
    chk("delay_s2_below_max", 32'(sc < 4), 1);

    // wide configuration, all-ones
    tt1 = 16'hFFFF;
    run(1, 16'hFFFF, 1'b0, lat, dones, sc, pf, sc_mid);
    chk("wide_score", sc, 16);
    chk("wide_perfect", pf, 1);
    chk("wide_latency", lat, 41);

    for (int k = 0; k < 8; k++) begin
      tt0  = 4'($urandom);
      rtgt = 16'($urandom);
      exp_sc = ref_score(4, {12'h0, tt0}, rtgt);
      run(0, rtgt, 1'b0, lat, dones, sc, pf, sc_mid);
      chk("rand0_score", sc, exp_sc);
      chk("rand0_perfect", pf, (exp_sc == 4) ? 1 : 0);
      chk("rand0_latency", lat, 21);
    end

    for (int k = 0; k < 4; k++) begin
      tt1  = 16'($urandom);
      rtgt = (k == 3) ? tt1 : 16'($urandom);
      exp_sc = ref_score(16, tt1, rtgt);
      run(1, rtgt, 1'b0, lat, dones, sc, pf, sc_mid);
      chk("rand1_score", sc, exp_sc);
      chk("rand1_perfect", pf, (exp_sc == 16) ? 1 : 0);
      chk("rand1_latency", lat, 41);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
